// File: rtl/fp_align_shift.sv
// fp_align_shift: mantissa alignment stage of the FP adder.
// Takes the exponent subtractor result (|diff| + borrow), picks the operand
// with the larger exponent and right-shifts the other mantissa by |diff|,
// at most STEP bits per cycle, collecting guard/round/sticky on the way.
// Only one operation is in flight; valid/ready handshakes on both sides.
module fp_align_shift #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [EXP_W-1:0]  diff,
  input  logic              borrow,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W+2:0] mant_small,
  output logic              swapped
);

  localparam int W = MANT_W + 3;
  localparam logic [EXP_W-1:0] STEP_E = EXP_W'(STEP);
  localparam logic [EXP_W-1:0] W_E    = EXP_W'(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [EXP_W-1:0]  rem_r;
  logic [EXP_W-1:0]  amt_s;
  logic [W-1:0]      ext_r;
  logic [W-1:0]      ext_shift_s;
  logic              sticky_s;
  logic              accept_s;
  logic              sat_s;
  logic [MANT_W-1:0] small_s;
  logic [MANT_W-1:0] big_s;

  // The aligned mantissa is the shift register itself.
  assign mant_small = ext_r;

  // Operand routing: borrow means B carries the larger exponent.
  always_comb begin
    if (borrow) begin
      small_s = mant_a;
      big_s   = mant_b;
    end else begin
      small_s = mant_b;
      big_s   = mant_a;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE:    in_ready  = ~rst;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Accept and saturation decode for the capture cycle.
  always_comb begin
    accept_s = in_valid & in_ready;
    sat_s    = (diff >= W_E);
  end

  // One shift step: move right by min(STEP, rem) and fold every bit that
  // falls off (plus the old sticky) into bit 0.
  always_comb begin
    if (rem_r > STEP_E) begin
      amt_s = STEP_E;
    end else begin
      amt_s = rem_r;
    end
    sticky_s = 1'b0;
    for (int i = 0; i < W; i++) begin
      sticky_s = sticky_s | (ext_r[i] & (i <= int'(amt_s)));
    end
    ext_shift_s = ext_r >> amt_s;
    ext_shift_s[0] = sticky_s;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: zero or saturating shifts finish in the capture cycle;
  // the shift step that consumes the last STEP or fewer bits finishes SHIFT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if ((diff == {EXP_W{1'b0}}) || sat_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (rem_r <= STEP_E) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath registers: capture on accept, shift in SHIFT, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_r    <= {W{1'b0}};
      rem_r    <= {EXP_W{1'b0}};
      exp_out  <= {EXP_W{1'b0}};
      mant_big <= {MANT_W{1'b0}};
      swapped  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            exp_out  <= borrow ? exp_b : exp_a;
            mant_big <= big_s;
            swapped  <= borrow;
            rem_r    <= diff;
            if (sat_s) begin
              ext_r <= {{(W-1){1'b0}}, |small_s};
            end else begin
              ext_r <= {small_s, 3'b000};
            end
          end
        end
        SHIFT: begin
          ext_r <= ext_shift_s;
          rem_r <= rem_r - amt_s;
        end
        DONE: begin
          ext_r <= ext_r;
        end
        default: begin
          ext_r <= ext_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_shift.sv
// Directed bench for fp_align_shift (MANT_W=24, EXP_W=8, STEP=4).
// Expected results come from a whole-number model: the aligned value is the
// extended mantissa shifted by diff in one go, with bit 0 replaced by the OR
// of every bit at or below position diff.
module tb_fp_align_shift;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [7:0]  diff;
  logic        borrow;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [23:0] mant_big;
  logic [26:0] mant_small;
  logic        swapped;

  int n_pass  = 0;
  int n_total = 0;

  logic        model_valid = 1'b0;
  logic [26:0] exp_ms;
  logic [23:0] exp_mb;
  logic [7:0]  exp_eo;
  logic        exp_sw;
  int          exp_lat;

  logic [26:0] got_ms;
  logic [23:0] got_mb;
  logic [7:0]  got_eo;
  logic        got_sw;
  int          got_lat;

  fp_align_shift #(.MANT_W(24), .EXP_W(8), .STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .diff(diff), .borrow(borrow),
    .mant_a(mant_a), .mant_b(mant_b), .out_valid(out_valid),
    .out_ready(out_ready), .exp_out(exp_out), .mant_big(mant_big),
    .mant_small(mant_small), .swapped(swapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [26:0] model_small(input logic [23:0] s, input int d);
    logic [63:0] e;
    logic [63:0] r;
    e = {37'd0, s, 3'b000};
    if (d >= 27) begin
      r = {63'd0, |s};
    end else begin
      r = e >> d;
      r[0] = |(e & ((64'd1 << (d + 1)) - 64'd1));
    end
    return r[26:0];
  endfunction

  function automatic int model_lat(input int d);
    if (d == 0 || d >= 27) return 1;
    return 1 + (d + 3) / 4;
  endfunction

  // Output checker: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (model_valid && out_valid === 1'b1) begin
      check("mant_small", 64'(mant_small), 64'(exp_ms));
      check("mant_big", 64'(mant_big), 64'(exp_mb));
      check("exp_out", 64'(exp_out), 64'(exp_eo));
      check("swapped", 64'(swapped), 64'(exp_sw));
    end
  end

  task automatic run_op(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] d,
                        input logic b, input logic [23:0] ma, input logic [23:0] mb,
                        input int hold);
    int cyc;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    exp_a = ea; exp_b = eb; diff = d; borrow = b; mant_a = ma; mant_b = mb;
    in_valid = 1'b1;
    exp_sw  = b;
    exp_eo  = b ? eb : ea;
    exp_mb  = b ? mb : ma;
    exp_ms  = model_small(b ? ma : mb, int'(d));
    exp_lat = model_lat(int'(d));
    model_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_a = 8'($urandom); exp_b = 8'($urandom); diff = 8'($urandom);
    borrow = 1'($urandom); mant_a = 24'($urandom); mant_b = 24'($urandom);
    @(negedge clk);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    got_lat = cyc; got_ms = mant_small; got_mb = mant_big; got_eo = exp_out; got_sw = swapped;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      diff = 8'd3; mant_a = 24'h123456; mant_b = 24'h654321;
      check("in_ready_busy", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("in_ready_done", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    model_valid = 1'b0;
    check("out_valid_after_hs", 64'(out_valid), 64'd0);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    exp_a = 8'd1; exp_b = 8'd2; diff = 8'd0; borrow = 1'b0;
    mant_a = 24'hFFFFFF; mant_b = 24'hFFFFFF;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mant_small", 64'(mant_small), 64'd0);
    check("rst_mant_big", 64'(mant_big), 64'd0);
    check("rst_exp_out", 64'(exp_out), 64'd0);
    check("rst_swapped", 64'(swapped), 64'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // 1: basic alignment, two shift steps
    run_op(8'd85, 8'd80, 8'd5, 1'b0, 24'h800000, 24'hC00000, 0);
    check("t1_small", 64'(got_ms), 64'h0300000);
    check("t1_big", 64'(got_mb), 64'h800000);
    check("t1_exp", 64'(got_eo), 64'd85);
    check("t1_swapped", 64'(got_sw), 64'd0);
    check("t1_lat", 64'(got_lat), 64'd3);
    // 2: sticky from a dropped bit
    run_op(8'd90, 8'd86, 8'd4, 1'b0, 24'hFFFFFF, 24'h800001, 0);
    check("t2_small", 64'(got_ms), 64'h0400001);
    check("t2_lat", 64'(got_lat), 64'd2);
    // 3: swap
    run_op(8'd80, 8'd82, 8'd2, 1'b1, 24'hA00000, 24'h800000, 0);
    check("t3_small", 64'(got_ms), 64'h1400000);
    check("t3_big", 64'(got_mb), 64'h800000);
    check("t3_exp", 64'(got_eo), 64'd82);
    check("t3_swapped", 64'(got_sw), 64'd1);
    check("t3_lat", 64'(got_lat), 64'd2);
    // 4: saturation and zero shift
    run_op(8'd130, 8'd100, 8'd30, 1'b0, 24'h912345, 24'h800000, 0);
    check("t4_sat_small", 64'(got_ms), 64'h0000001);
    check("t4_sat_lat", 64'(got_lat), 64'd1);
    run_op(8'd50, 8'd50, 8'd0, 1'b0, 24'hABCDEF, 24'h876543, 0);
    check("t4_zero_small", 64'(got_ms), 64'h43B2A18);
    check("t4_zero_lat", 64'(got_lat), 64'd1);
    // 5: backpressure with ignored input traffic
    run_op(8'd100, 8'd99, 8'd1, 1'b0, 24'hFFFFFF, 24'hC00001, 3);
    check("t5_small", 64'(got_ms), 64'h3000004);
    // boundaries around W
    run_op(8'd40, 8'd16, 8'd24, 1'b0, 24'h111111, 24'h800000, 0);
    check("d24_small", 64'(got_ms), 64'h0000004);
    check("d24_lat", 64'(got_lat), 64'd7);
    run_op(8'd40, 8'd14, 8'd26, 1'b0, 24'h111111, 24'hC00000, 0);
    check("d26_small", 64'(got_ms), 64'h0000001);
    check("d26_lat", 64'(got_lat), 64'd8);
    run_op(8'd40, 8'd13, 8'd27, 1'b0, 24'h111111, 24'h800000, 1);
    check("d27_lat", 64'(got_lat), 64'd1);
    run_op(8'd10, 8'd18, 8'd8, 1'b1, 24'hFFFFFF, 24'h9ABCDE, 0);
    check("d8_small", 64'(got_ms), 64'h007FFFF);
    check("d8_lat", 64'(got_lat), 64'd3);

    // 6: reset in the middle of a shift
    @(negedge clk);
    exp_a = 8'd60; exp_b = 8'd40; diff = 8'd20; borrow = 1'b0;
    mant_a = 24'hFFFFFF; mant_b = 24'hFFFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_busy", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_small", 64'(mant_small), 64'd0);
    check("t6_big", 64'(mant_big), 64'd0);
    check("t6_exp", 64'(exp_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_in_ready", 64'(in_ready), 64'd1);
    run_op(8'd70, 8'd69, 8'd1, 1'b0, 24'h000000, 24'h800001, 0);
    check("t6_next_small", 64'(got_ms), 64'h2000004);
    check("t6_next_lat", 64'(got_lat), 64'd2);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
